countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
// PURPOSE
// Countdown timer control core that produces the data consumed by the countdown display scanner.
// Drives:
//   - the edit value tmp1, with the selected digit index state;
//   - the running value tmp;
//   - the go and finish flags.
// The user edits an HH:MM:SS preset, starts, pauses and resumes the countdown. The block
// flags completion and auto-returns to edit mode.
// PARAMETERS
// INIT_VALUE   32'h00B05B00  tmp1 value after reset (00:05:00)
// HOUR_T_MAX   9             max hour-tens digit (hours limited to HOUR_T_MAX9)
// DONE_HOLD    10            seconds spent in DONE before auto-return to SET; 0 = stay forever
// PORTS
// clk        in   1   system clock (same clock as display scanner)
// rst        in   1   synchronous reset, active-high
// tick       in   1   one-clk enable pulse, 1 Hz
// btn_left   in   1   one-clk pulse, debounced upstream: select next-higher digit
// btn_right  in   1   one-clk pulse: select next-lower digit
// btn_up     in   1   one-clk pulse: increment selected digit
// btn_down   in   1   one-clk pulse: decrement selected digit
// btn_start  in   1   one-clk pulse: start / pause / resume / acknowledge
// tmp1       out  32  edit value, packed BCD
// tmp        out  32  running value, same packing as tmp1
// state      out  4   selected digit: 1=s1, 2=s10, 3=m1, 4=m10, 5=h1, 6=h10; 0 = none
// go         out  1   1 in RUN/PAUSE (display shows tmp)
// finish     out  1   1 in DONE (display blinks tmp)
// BEHAVIOUR
// - Packing, nibbles high to low: [31:28]=h10, [27:24]=h1, [23:20]=4'hB, [19:16]=m10,
//   [15:12]=m1, [11:8]=4'hB, [7:4]=s10, [3:0]=s1. Separator nibbles are always 4'hB.
// - Timing: all outputs registered. A button or tick pulse takes effect on the next clk edge.
// - Reset: ctrl=SET, tmp1=INIT_VALUE, tmp=32'h00B00B00, state=1, go=0, finish=0, done counter=0.
// - FSM states: SET, RUN, PAUSE, DONE. Outputs per state:
//   - state is 0 outside SET.
//   - go=1 in RUN and PAUSE, else 0.
//   - finish=1 only in DONE.
// - Digit limits: s1,m1,h1 0..9; s10,m10 0..5; h10 0..HOUR_T_MAX.
// - SET:
//   - btn_left: state 1->2->..->6->1 (wraps).
//   - btn_right: state 6->5->..->1->6 (wraps).
//   - btn_up/btn_down: selected digit +1/-1, wrapping within its limit. No carry into
//     neighbouring digits.
//   - btn_start with tmp1 != 00:00:00: tmp<=tmp1, ->RUN.
//   - btn_start with tmp1 == 00:00:00: ignored.
// - RUN:
//   - tick: tmp decremented by one second using BCD borrow chain
//     (s1 -> s10 (wrap to 5) -> m1 -> m10 (wrap to 5) -> h1 -> h10).
//   - If the decremented value is 00:00:00, ->DONE on the same edge as the load of zeros.
//   - btn_start: ->PAUSE. Other buttons ignored.
// - PAUSE:
//   - tmp frozen; ticks ignored.
//   - btn_start: ->RUN.
//   - btn_left: ->SET, tmp cleared to 00:00:00, tmp1 kept, state=1.
// - DONE:
//   - tmp holds 00:00:00.
//   - A counter increments on each tick. When it reaches DONE_HOLD, or on btn_start:
//     ->SET, state=1, counter cleared, tmp1 kept.
// - Simultaneous events:
//   - RUN, btn_start with tick: pause wins, no decrement.
//   - SET, btn_left with btn_right: no move.
//   - SET, btn_up with btn_down: no change.
//   - SET, btn_start with an edit button: start uses tmp1 before the edit; the edit is dropped.
// - rst at any time, including mid-countdown, forces the reset values on the next edge.
// TESTING
// - Reset, then 1 clk -> tmp1=00B05B00, tmp=00B00B00, state=1, go=0, finish=0.
// - SET, state=2, 5x btn_up from s10=0 -> s10 reads 1,2,3,4,5; 6th press -> 0;
//   btn_down at 0 -> 5.
// - tmp1=01B00B00, start, 1 tick -> tmp=00B59B59, go=1; 3599 more ticks -> tmp=00B00B00,
//   finish=1, go=0.
// - tmp1=00B00B00, btn_start -> stays SET, go=0. Then tmp1=00B00B02, start, tick with
//   btn_start same clk -> PAUSE, tmp=00B00B02.
// - DONE, DONE_HOLD=10: 9 ticks -> finish=1; 10th tick -> SET, state=1, tmp1 unchanged.
// - RUN at 00B10B00, rst high 1 clk -> all outputs at reset values, tick afterwards changes
//   nothing.

Source files
------------

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: HH:MM:SS countdown timer control core.
// Owns the edit value (tmp1), the running value (tmp), the selected digit index
// and the go/finish flags that the display scanner consumes. All outputs are registered.
module countdown_ctrl #(
    parameter logic [31:0] INIT_VALUE = 32'h00B05B00,
    parameter int          HOUR_T_MAX = 9,
    parameter int          DONE_HOLD  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_start,
    output logic [31:0] tmp1,
    output logic [31:0] tmp,
    output logic [3:0]  state,
    output logic        go,
    output logic        finish
);

    localparam logic [1:0] ST_SET   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // 00:00:00 with the separator nibbles in place
    localparam logic [31:0] ZERO_VAL = 32'h00B00B00;
    localparam logic [3:0]  H10_MAX  = 4'(HOUR_T_MAX);
    localparam int          CNT_W    = (DONE_HOLD < 2) ? 1 : $clog2(DONE_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_HOLD - 1);

    // Upper limit of the digit selected by index 1..6
    function automatic logic [3:0] dig_max(input logic [3:0] sel);
        case (sel)
            4'd2, 4'd4: dig_max = 4'd5;
            4'd6:       dig_max = H10_MAX;
            default:    dig_max = 4'd9;
        endcase
    endfunction

    // Bit position of the nibble for digit index 1..6 (separators skipped)
    function automatic logic [4:0] dig_pos(input logic [3:0] sel);
        case (sel)
            4'd2:    dig_pos = 5'd4;
            4'd3:    dig_pos = 5'd12;
            4'd4:    dig_pos = 5'd16;
            4'd5:    dig_pos = 5'd24;
            4'd6:    dig_pos = 5'd28;
            default: dig_pos = 5'd0;
        endcase
    endfunction

    // One-second BCD decrement; borrows ripple s1 -> s10 -> m1 -> m10 -> h1 -> h10.
    // Only ever applied to a nonzero value, so h10 never needs to wrap.
    function automatic logic [31:0] bcd_dec(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (v[15:12] != 4'd0) r[15:12] = v[15:12] - 4'd1;
                else begin
                    r[15:12] = 4'd9;
                    if (v[19:16] != 4'd0) r[19:16] = v[19:16] - 4'd1;
                    else begin
                        r[19:16] = 4'd5;
                        if (v[27:24] != 4'd0) r[27:24] = v[27:24] - 4'd1;
                        else begin
                            r[27:24] = 4'd9;
                            r[31:28] = v[31:28] - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    logic [1:0]       ctrl_q,   ctrl_d;
    logic [31:0]      tmp1_q,   tmp1_d;
    logic [31:0]      tmp_q,    tmp_d;
    logic [3:0]       state_q,  state_d;
    logic             go_q,     go_d;
    logic             finish_q, finish_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic [4:0] pos;
    logic [3:0] cur_dig;
    logic [3:0] max_dig;
    logic [3:0] new_dig;
    logic [31:0] dec_val;

    // Next-state logic for the FSM and all datapath registers
    always_comb begin
        ctrl_d  = ctrl_q;
        tmp1_d  = tmp1_q;
        tmp_d   = tmp_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pos     = dig_pos(state_q);
        cur_dig = tmp1_q[pos +: 4];
        max_dig = dig_max(state_q);
        new_dig = cur_dig;
        dec_val = bcd_dec(tmp_q);

        case (ctrl_q)
            ST_SET: begin
                if (btn_start && tmp1_q != ZERO_VAL) begin
                    // Start captures tmp1 as it was; any same-cycle edit is dropped
                    ctrl_d = ST_RUN;
                    tmp_d  = tmp1_q;
                end else begin
                    if (btn_left && !btn_right)
                        state_d = (state_q >= 4'd6) ? 4'd1 : state_q + 4'd1;
                    else if (btn_right && !btn_left)
                        state_d = (state_q <= 4'd1) ? 4'd6 : state_q - 4'd1;
                    if (btn_up && !btn_down)
                        new_dig = (cur_dig >= max_dig) ? 4'd0 : cur_dig + 4'd1;
                    else if (btn_down && !btn_up)
                        new_dig = (cur_dig == 4'd0) ? max_dig : cur_dig - 4'd1;
                    tmp1_d[pos +: 4] = new_dig;
                end
            end
            ST_RUN: begin
                // Pause has priority over a coincident tick
                if (btn_start) ctrl_d = ST_PAUSE;
                else if (tick) begin
                    tmp_d = dec_val;
                    if (dec_val == ZERO_VAL) ctrl_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (btn_start) ctrl_d = ST_RUN;
                else if (btn_left) begin
                    ctrl_d  = ST_SET;
                    tmp_d   = ZERO_VAL;
                    state_d = 4'd1;
                end
            end
            default: begin
                if (btn_start) begin
                    ctrl_d  = ST_SET;
                    state_d = 4'd1;
                    cnt_d   = '0;
                end else if (tick && DONE_HOLD != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        ctrl_d  = ST_SET;
                        state_d = 4'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase

        // No digit is selected outside SET
        if (ctrl_d != ST_SET) state_d = 4'd0;
        go_d     = (ctrl_d == ST_RUN) || (ctrl_d == ST_PAUSE);
        finish_d = (ctrl_d == ST_DONE);
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= ST_SET;
            tmp1_q   <= INIT_VALUE;
            tmp_q    <= ZERO_VAL;
            state_q  <= 4'd1;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            tmp1_q   <= tmp1_d;
            tmp_q    <= tmp_d;
            state_q  <= state_d;
            go_q     <= go_d;
            finish_q <= finish_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tmp1   = tmp1_q;
    assign tmp    = tmp_q;
    assign state  = state_q;
    assign go     = go_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: vector tables plus hand-written long sequences.
module tb_countdown_ctrl;

    logic        clk = 1'b0;
    logic        rst, tick, btn_left, btn_right, btn_up, btn_down, btn_start;
    logic [31:0] tmp1, tmp;
    logic [3:0]  state;
    logic        go, finish;

    int errors = 0;
    int checks = 0;

    // Input encoding {rst, tick, left, right, up, down, start}
    localparam logic [6:0] B_NONE = 7'b0000000;
    localparam logic [6:0] B_RST  = 7'b1000000;
    localparam logic [6:0] B_TICK = 7'b0100000;
    localparam logic [6:0] B_L    = 7'b0010000;
    localparam logic [6:0] B_R    = 7'b0001000;
    localparam logic [6:0] B_U    = 7'b0000100;
    localparam logic [6:0] B_D    = 7'b0000010;
    localparam logic [6:0] B_S    = 7'b0000001;

    typedef struct {
        logic [6:0]  in;
        logic [31:0] e_tmp1;
        logic [31:0] e_tmp;
        logic [3:0]  e_state;
        logic        e_go;
        logic        e_fin;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    countdown_ctrl #(
        .INIT_VALUE(32'h00B05B00),
        .HOUR_T_MAX(9),
        .DONE_HOLD (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_start(btn_start),
        .tmp1     (tmp1),
        .tmp      (tmp),
        .state    (state),
        .go       (go),
        .finish   (finish)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [6:0] in, input logic [31:0] t1, input logic [31:0] t,
                                input logic [3:0] st, input logic g, input logic f);
        vec_t v;
        v.in = in; v.e_tmp1 = t1; v.e_tmp = t; v.e_state = st; v.e_go = g; v.e_fin = f;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the edge
    task automatic step(input logic [6:0] in);
        @(negedge clk);
        {rst, tick, btn_left, btn_right, btn_up, btn_down, btn_start} = in;
        @(posedge clk);
        #1;
        {rst, tick, btn_left, btn_right, btn_up, btn_down, btn_start} = B_NONE;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input vec_t v);
        chk({tag, ".tmp1"},   idx, tmp1,   v.e_tmp1);
        chk({tag, ".tmp"},    idx, tmp,    v.e_tmp);
        chk({tag, ".state"},  idx, {28'd0, state},  {28'd0, v.e_state});
        chk({tag, ".go"},     idx, {31'd0, go},     {31'd0, v.e_go});
        chk({tag, ".finish"}, idx, {31'd0, finish}, {31'd0, v.e_fin});
    endtask

    initial begin
        {rst, tick, btn_left, btn_right, btn_up, btn_down, btn_start} = B_NONE;

        // Edit-mode walk from reset through to a 01:00:00 start
        tab_a.push_back(mk(B_RST,     32'h00B05B00, 32'h00B00B00, 4'd1, 0, 0));
        tab_a.push_back(mk(B_NONE,    32'h00B05B00, 32'h00B00B00, 4'd1, 0, 0));
        tab_a.push_back(mk(B_L,       32'h00B05B00, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_U,       32'h00B05B10, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_U,       32'h00B05B20, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_U,       32'h00B05B30, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_U,       32'h00B05B40, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_U,       32'h00B05B50, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_U,       32'h00B05B00, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_D,       32'h00B05B50, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_L | B_R, 32'h00B05B50, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_U | B_D, 32'h00B05B50, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_R,       32'h00B05B50, 32'h00B00B00, 4'd1, 0, 0));
        tab_a.push_back(mk(B_R,       32'h00B05B50, 32'h00B00B00, 4'd6, 0, 0));
        tab_a.push_back(mk(B_L,       32'h00B05B50, 32'h00B00B00, 4'd1, 0, 0));
        tab_a.push_back(mk(B_L,       32'h00B05B50, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_U,       32'h00B05B00, 32'h00B00B00, 4'd2, 0, 0));
        tab_a.push_back(mk(B_L,       32'h00B05B00, 32'h00B00B00, 4'd3, 0, 0));
        tab_a.push_back(mk(B_D,       32'h00B04B00, 32'h00B00B00, 4'd3, 0, 0));
        tab_a.push_back(mk(B_D,       32'h00B03B00, 32'h00B00B00, 4'd3, 0, 0));
        tab_a.push_back(mk(B_D,       32'h00B02B00, 32'h00B00B00, 4'd3, 0, 0));
        tab_a.push_back(mk(B_D,       32'h00B01B00, 32'h00B00B00, 4'd3, 0, 0));
        tab_a.push_back(mk(B_D,       32'h00B00B00, 32'h00B00B00, 4'd3, 0, 0));
        tab_a.push_back(mk(B_S,       32'h00B00B00, 32'h00B00B00, 4'd3, 0, 0));
        tab_a.push_back(mk(B_L,       32'h00B00B00, 32'h00B00B00, 4'd4, 0, 0));
        tab_a.push_back(mk(B_L,       32'h00B00B00, 32'h00B00B00, 4'd5, 0, 0));
        tab_a.push_back(mk(B_U,       32'h01B00B00, 32'h00B00B00, 4'd5, 0, 0));
        tab_a.push_back(mk(B_L,       32'h01B00B00, 32'h00B00B00, 4'd6, 0, 0));
        tab_a.push_back(mk(B_U,       32'h11B00B00, 32'h00B00B00, 4'd6, 0, 0));
        tab_a.push_back(mk(B_D,       32'h01B00B00, 32'h00B00B00, 4'd6, 0, 0));
        tab_a.push_back(mk(B_D,       32'h91B00B00, 32'h00B00B00, 4'd6, 0, 0));
        tab_a.push_back(mk(B_U,       32'h01B00B00, 32'h00B00B00, 4'd6, 0, 0));
        tab_a.push_back(mk(B_S | B_U, 32'h01B00B00, 32'h01B00B00, 4'd0, 1, 0));
        tab_a.push_back(mk(B_TICK,    32'h01B00B00, 32'h00B59B59, 4'd0, 1, 0));

        // Pause/resume, done-acknowledge, pause-abort and mid-run reset
        tab_b.push_back(mk(B_R,          32'h01B00B00, 32'h00B00B00, 4'd6, 0, 0));
        tab_b.push_back(mk(B_R,          32'h01B00B00, 32'h00B00B00, 4'd5, 0, 0));
        tab_b.push_back(mk(B_D,          32'h00B00B00, 32'h00B00B00, 4'd5, 0, 0));
        tab_b.push_back(mk(B_L,          32'h00B00B00, 32'h00B00B00, 4'd6, 0, 0));
        tab_b.push_back(mk(B_L,          32'h00B00B00, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_U,          32'h00B00B01, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_U,          32'h00B00B02, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_S,          32'h00B00B02, 32'h00B00B02, 4'd0, 1, 0));
        tab_b.push_back(mk(B_TICK | B_S, 32'h00B00B02, 32'h00B00B02, 4'd0, 1, 0));
        tab_b.push_back(mk(B_TICK,       32'h00B00B02, 32'h00B00B02, 4'd0, 1, 0));
        tab_b.push_back(mk(B_S,          32'h00B00B02, 32'h00B00B02, 4'd0, 1, 0));
        tab_b.push_back(mk(B_TICK,       32'h00B00B02, 32'h00B00B01, 4'd0, 1, 0));
        tab_b.push_back(mk(B_TICK,       32'h00B00B02, 32'h00B00B00, 4'd0, 0, 1));
        tab_b.push_back(mk(B_S,          32'h00B00B02, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_S,          32'h00B00B02, 32'h00B00B02, 4'd0, 1, 0));
        tab_b.push_back(mk(B_S,          32'h00B00B02, 32'h00B00B02, 4'd0, 1, 0));
        tab_b.push_back(mk(B_L,          32'h00B00B02, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_L,          32'h00B00B02, 32'h00B00B00, 4'd2, 0, 0));
        tab_b.push_back(mk(B_L,          32'h00B00B02, 32'h00B00B00, 4'd3, 0, 0));
        tab_b.push_back(mk(B_L,          32'h00B00B02, 32'h00B00B00, 4'd4, 0, 0));
        tab_b.push_back(mk(B_U,          32'h00B10B02, 32'h00B00B00, 4'd4, 0, 0));
        tab_b.push_back(mk(B_R,          32'h00B10B02, 32'h00B00B00, 4'd3, 0, 0));
        tab_b.push_back(mk(B_R,          32'h00B10B02, 32'h00B00B00, 4'd2, 0, 0));
        tab_b.push_back(mk(B_R,          32'h00B10B02, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_D,          32'h00B10B01, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_D,          32'h00B10B00, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_S,          32'h00B10B00, 32'h00B10B00, 4'd0, 1, 0));
        tab_b.push_back(mk(B_TICK,       32'h00B10B00, 32'h00B09B59, 4'd0, 1, 0));
        tab_b.push_back(mk(B_RST,        32'h00B05B00, 32'h00B00B00, 4'd1, 0, 0));
        tab_b.push_back(mk(B_TICK,       32'h00B05B00, 32'h00B00B00, 4'd1, 0, 0));

        for (int i = 0; i < tab_a.size(); i++) begin
            step(tab_a[i].in);
            check_all("a", i, tab_a[i]);
        end

        // Full hour countdown: one second before the end, then the final tick
        for (int i = 0; i < 3598; i++) step(B_TICK);
        check_all("run_last", 0, mk(B_NONE, 32'h01B00B00, 32'h00B00B01, 4'd0, 1, 0));
        step(B_TICK);
        check_all("run_zero", 0, mk(B_NONE, 32'h01B00B00, 32'h00B00B00, 4'd0, 0, 1));

        // DONE hold: nine ticks stay in DONE, the tenth returns to SET
        for (int i = 0; i < 9; i++) begin
            step(B_NONE);
            step(B_TICK);
        end
        check_all("done_hold", 9, mk(B_NONE, 32'h01B00B00, 32'h00B00B00, 4'd0, 0, 1));
        step(B_TICK);
        check_all("done_exit", 10, mk(B_NONE, 32'h01B00B00, 32'h00B00B00, 4'd1, 0, 0));

        for (int i = 0; i < tab_b.size(); i++) begin
            step(tab_b[i].in);
            check_all("b", i, tab_b[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
